// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: left-justified MSB-first L/R words -> one-deep valid/ready pair register.
// Define AUDIO_ADC_FRAME_CHECK_EN to reject short words with an oFRAME_ERR pulse instead of zero-filling them.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST_N,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_ADCLRCK,
  input  logic                  iAUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] oLEFT,
  output logic [DATA_WIDTH-1:0] oRIGHT,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic                  oOVERRUN,
  output logic                  oFRAME_ERR
);
  localparam int            CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  // Identical-depth chains; the top stage of each is the history flop, so LRCK/DAT
  // are taken at the same instant as the pre-edge BCK sample.
  logic [SYNC_STAGES:0] bck_pipe, lr_pipe, dat_pipe;

  logic [1:0]            state;
  logic                  lr_q;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] left_q;
  logic                  have_left;

  logic                  bit_ev, lr_in, dat_in;
  logic                  word_start, shift_ev, full_done, short_done, word_done;
  logic                  frame_bad, left_ld, pair_done;
  logic [DATA_WIDTH-1:0] bit_mask, word_val;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_pipe <= '0;
      lr_pipe  <= '0;
      dat_pipe <= '0;
    end else begin
      bck_pipe <= {bck_pipe[SYNC_STAGES-1:0], iAUD_BCK};
      lr_pipe  <= {lr_pipe[SYNC_STAGES-1:0], iAUD_ADCLRCK};
      dat_pipe <= {dat_pipe[SYNC_STAGES-1:0], iAUD_ADCDAT};
    end
  end

  always_comb begin
    bit_ev     = bck_pipe[SYNC_STAGES-1] & ~bck_pipe[SYNC_STAGES];
    lr_in      = lr_pipe[SYNC_STAGES];
    dat_in     = dat_pipe[SYNC_STAGES];
    word_start = bit_ev && (lr_in != lr_q);
    shift_ev   = bit_ev && !word_start && (bit_cnt < CNT_FULL);
    // Bits land at their final MSB-first position, so a short word is already zero-filled.
    bit_mask   = DATA_WIDTH'(dat_in) << (CNT_LAST - bit_cnt);
    full_done  = shift_ev && (bit_cnt == CNT_LAST) && (state != ST_SYNC);
    short_done = word_start && (bit_cnt != '0) && (bit_cnt < CNT_FULL) && (state != ST_SYNC);
    word_done  = full_done || short_done;
    word_val   = full_done ? (sh | bit_mask) : sh;
`ifdef AUDIO_ADC_FRAME_CHECK_EN
    frame_bad  = short_done;
`else
    frame_bad  = 1'b0;
`endif
    left_ld    = (state == ST_LEFT) && word_done && !frame_bad;
    pair_done  = (state == ST_RIGHT) && word_done && have_left && !frame_bad;
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      lr_q    <= 1'b0;
      bit_cnt <= '0;
      sh      <= '0;
    end else if (word_start) begin
      lr_q    <= lr_in;
      bit_cnt <= CW'(1);
      sh      <= {dat_in, {(DATA_WIDTH-1){1'b0}}};
    end else if (shift_ev) begin
      bit_cnt <= bit_cnt + CW'(1);
      sh      <= sh | bit_mask;
    end
  end

  // A nonzero bit_cnt in SYNC proves LRCK=0 was really observed, so a rise seen
  // straight out of reset (mid-left-word) is not mistaken for a frame start.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_SYNC;
    end else if (word_start) begin
      case (state)
        ST_SYNC:  if (lr_in && (bit_cnt != '0)) state <= ST_LEFT;
        ST_LEFT:  if (!lr_in) state <= ST_RIGHT;
        ST_RIGHT: if (lr_in) state <= ST_LEFT;
        default:  state <= ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      left_q    <= '0;
      have_left <= 1'b0;
    end else if (left_ld) begin
      left_q    <= word_val;
      have_left <= 1'b1;
    end else if (pair_done || frame_bad) begin
      have_left <= 1'b0;
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      oLEFT    <= '0;
      oRIGHT   <= '0;
      oVALID   <= 1'b0;
      oOVERRUN <= 1'b0;
    end else begin
      oOVERRUN <= 1'b0;
      if (pair_done) begin
        if (!oVALID || iREADY) begin
          oLEFT  <= left_q;
          oRIGHT <= word_val;
          oVALID <= 1'b1;
        end else begin
          oOVERRUN <= 1'b1;
        end
      end else if (oVALID && iREADY) begin
        oVALID <= 1'b0;
      end
    end
  end

`ifdef AUDIO_ADC_FRAME_CHECK_EN
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) oFRAME_ERR <= 1'b0;
    else         oFRAME_ERR <= frame_bad;
  end
`else
  assign oFRAME_ERR = 1'b0;
`endif

endmodule

// File: doc/audio_adc_rx.md
# audio_adc_rx

Serial audio receiver that deserializes the codec ADC stream into parallel stereo sample pairs. It uses the same frame format the DAC path transmits: left-justified, MSB first, DATA_WIDTH bits per channel, LRCK high = left. BCK, LRCK and data arrive asynchronously and are oversampled in the 18.432 MHz system clock domain. Completed L/R pairs are presented on a one-deep valid/ready holding register for the APU/audio mixer side.

## Interface
- DATA_WIDTH, 16, bits per channel word
- SYNC_STAGES, 2, synchronizer flops per serial input (≥2)

- iCLK_18_4  in  1  system clock, 18.432 MHz
- iRST_N  in  1  reset, asynchronous, active-low
- iAUD_BCK  in  1  codec bit clock (async to iCLK_18_4)
- iAUD_ADCLRCK  in  1  codec ADC word clock; 1 = left, 0 = right
- iAUD_ADCDAT  in  1  codec ADC serial data
- oLEFT  out  DATA_WIDTH  left sample of held pair
- oRIGHT  out  DATA_WIDTH  right sample of held pair
- oVALID  out  1  held pair valid
- iREADY  in  1  consumer accepts pair when oVALID && iREADY
- oOVERRUN  out  1  one-cycle pulse: completed pair dropped
- oFRAME_ERR  out  1  one-cycle pulse: malformed word (see Configuration)

## Operation
- All three serial inputs pass through SYNC_STAGES flops plus one history flop, all at identical depth so their relative alignment is preserved.
- A bit event is a cycle in which synced BCK goes 0→1. Synced LRCK and DAT are sampled on bit events only.
- Bit event with LRCK ≠ stored lr_q means word start:
  - the in-progress word is closed;
  - lr_q is updated;
  - bit_cnt = 1;
  - the sampled bit becomes the MSB.
- Any other bit event:
  - if bit_cnt < DATA_WIDTH, shift the bit in and increment bit_cnt;
  - otherwise ignore the bit; bit_cnt saturates at DATA_WIDTH.
- A word completes on its DATA_WIDTH-th bit.
- A word is short if it is closed by an LRCK change with bit_cnt < DATA_WIDTH. A short word is treated as complete, with its received bits left-aligned and LSBs zero-filled.
- FSM states:
  - SYNC: after reset. Ignore data until the first LRCK 0→1 word start, then go to LEFT. Partial frames are discarded.
  - LEFT: on left completion, latch the left word and set have_left. On LRCK 1→0, go to RIGHT.
  - RIGHT: on right completion with have_left set, issue pair_done and clear have_left. On LRCK 0→1, go to LEFT.
- Holding register on pair_done:
  - oVALID=0, or oVALID && iREADY in the same cycle: load oLEFT/oRIGHT, oVALID=1.
  - oVALID && !iREADY: new pair dropped, held data unchanged, oOVERRUN pulses.
- oVALID && iREADY with no pair_done: oVALID=0 next cycle; data outputs hold their last value.

## Timing
- Reset values: oLEFT=0, oRIGHT=0, oVALID=0, oOVERRUN=0, oFRAME_ERR=0. Internal state: SYNC, bit_cnt=0, have_left=0, lr_q=0.
- Assertion of iRST_N mid-word clears all state immediately. After release, the block resynchronizes via SYNC.
- Bit event latency: SYNC_STAGES+1 iCLK cycles after the BCK pin edge.
- oVALID/oOVERRUN/oFRAME_ERR are registered and change 1 cycle after the pair_done / error bit event.
- Input constraint: each BCK level is held ≥ SYNC_STAGES+1 iCLK cycles. Nominal BCK is 1.536 MHz (6-cycle half period). DAT and LRCK are stable around the BCK rising edge.
- Throughput: at most 1 pair per LRCK period. oVALID may stay high indefinitely.

## Configuration
- AUDIO_ADC_FRAME_CHECK_EN defined:
  - a short word pulses oFRAME_ERR;
  - have_left is cleared;
  - no pair is emitted for that frame;
  - the FSM continues with the new word.
- Undefined:
  - oFRAME_ERR is tied 0;
  - short words are zero-filled and used as normal.

## Test plan
- Reset, then frames with L=16'hA5C3, R=16'h0F0F, BCK half-period 6, iREADY=1 -> one oVALID cycle per frame with oLEFT=A5C3 and oRIGHT=0F0F; all outputs 0 during reset.
- Release reset mid-left word -> no oVALID until the first full L/R frame after an LRCK rise; first pair correct.
- iREADY=0 across pairs (A5C3/0F0F), then (1234/5678) -> first pair held, oOVERRUN pulses once, data unchanged; iREADY=1 -> oVALID=0 next cycle.
- iREADY=1 with oVALID=1 in the same cycle as pair_done (1234/5678) -> oVALID stays 1, outputs update to 1234/5678, no oOVERRUN.
- Left word of 12 bits 12'hABC, right 16'h0F0F:
  - macro off -> oLEFT=16'hABC0, oRIGHT=0F0F;
  - macro on -> oFRAME_ERR pulse, no oVALID for that frame, next good frame accepted.
- 18-bit words (16'hBEEF followed by 2'b11) -> oLEFT=BEEF; extra bits ignored; no error.
